// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: round-robin sharing of one APB master port between two requesters.
// Define APB_TIMEOUT_EN to abort ACCESS phases that stall for TO_CYCLES cycles with err=1.
module apb_rr_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8,
  parameter int TO_CYCLES = 15
) (
  input  logic          pclk,
  input  logic          Presetn,
  input  logic          req0,
  input  logic          wr0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          done0,
  input  logic          req1,
  input  logic          wr1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state, state_n;
  logic   gnt, last_grant;
  logic   elig0, elig1;
  logic   grant_now, grant_sel;
  logic   finish, abort;

  // A requester whose done is pulsing this cycle is still holding its old req.
  assign elig0 = req0 && !done0;
  assign elig1 = req1 && !done1;

`ifdef APB_TIMEOUT_EN
  localparam int CW = ($clog2(TO_CYCLES + 1) > 4) ? $clog2(TO_CYCLES + 1) : 4;

  logic [CW-1:0] to_cnt;
  logic          err_q;

  assign abort = (state == ACCESS) && !pready && (to_cnt == CW'(TO_CYCLES - 1));

  always_ff @(posedge pclk or negedge Presetn) begin
    if (!Presetn) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= abort;
      if (state == SETUP)
        to_cnt <= '0;
      else if (state == ACCESS && !pready)
        to_cnt <= to_cnt + 1'b1;
    end
  end

  assign err = err_q;
`else
  localparam int unused_to_cycles = TO_CYCLES;

  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  assign finish  = (state == ACCESS) && (pready || abort);
  assign psel    = (state != IDLE);
  assign penable = (state == ACCESS);

  always_ff @(posedge pclk or negedge Presetn) begin
    if (!Presetn)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    grant_now = 1'b0;
    grant_sel = 1'b0;
    unique case (state)
      IDLE: begin
        if (elig0 || elig1) begin
          grant_now = 1'b1;
          grant_sel = (elig0 && elig1) ? ~last_grant : elig1;
          state_n   = SETUP;
        end
      end
      SETUP:   state_n = ACCESS;
      ACCESS:  if (pready || abort) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Command latch, completion pulses and read capture.
  always_ff @(posedge pclk or negedge Presetn) begin
    if (!Presetn) begin
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      rdata      <= '0;
      done0      <= 1'b0;
      done1      <= 1'b0;
    end else begin
      done0 <= finish && !gnt;
      done1 <= finish && gnt;
      if (grant_now) begin
        gnt    <= grant_sel;
        pwrite <= grant_sel ? wr1 : wr0;
        paddr  <= grant_sel ? addr1 : addr0;
        pwdata <= grant_sel ? wdata1 : wdata0;
      end
      if (finish) begin
        last_grant <= gnt;
        if (pready && !pwrite)
          rdata <= prdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// tb_apb_rr_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_apb_rr_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int TO_CYCLES = 15;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  logic          pclk = 1'b0;
  logic          Presetn = 1'b0;
  logic          req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          done0, done1, err, psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, rdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;

  int checks = 0;
  int errors = 0;

  apb_rr_arbiter #(.AW(AW), .DW(DW), .TO_CYCLES(TO_CYCLES)) dut (
    .pclk(pclk), .Presetn(Presetn),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .done0(done0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .done1(done1),
    .rdata(rdata), .err(err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  task automatic test_reset();
    $display("[TB] test_reset");
    req0 = 1'b0; req1 = 1'b0; pready = 1'b0;
    @(negedge pclk);
    Presetn = 1'b0;
    #1;
    checks++;
    if ({psel, penable, pwrite} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %b expected 000", {psel, penable, pwrite});
    end
    checks++;
    if ({paddr, pwdata, rdata} !== '0) begin
      errors++; $display("[TB] FAIL reset_data: got %h/%h/%h expected 0", paddr, pwdata, rdata);
    end
    checks++;
    if ({done0, done1, err} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_status: got %b expected 000", {done0, done1, err});
    end
    @(negedge pclk);
    Presetn = 1'b1;
  endtask

  task automatic test_write();
    $display("[TB] test_write");
    @(negedge pclk);
    req0 = 1'b1; wr0 = 1'b1; addr0 = 4'h3; wdata0 = 8'hA5; pready = 1'b1;
    @(negedge pclk);
    checks++;
    if ({psel, penable} !== 2'b10) begin
      errors++; $display("[TB] FAIL wr_setup: got %b expected 10", {psel, penable});
    end
    checks++;
    if ({pwrite, paddr, pwdata} !== {1'b1, 4'h3, 8'hA5}) begin
      errors++; $display("[TB] FAIL wr_cmd: got %b/%h/%h expected 1/3/a5", pwrite, paddr, pwdata);
    end
    @(negedge pclk);
    checks++;
    if ({psel, penable, done0} !== 3'b110) begin
      errors++; $display("[TB] FAIL wr_access: got %b expected 110", {psel, penable, done0});
    end
    @(negedge pclk);
    checks++;
    if ({done0, done1, err, psel} !== 4'b1000) begin
      errors++; $display("[TB] FAIL wr_done: got %b expected 1000", {done0, done1, err, psel});
    end
    checks++;
    if (rdata !== 8'h00) begin
      errors++; $display("[TB] FAIL wr_rdata: got %h expected 00", rdata);
    end
    req0 = 1'b0;
    @(negedge pclk);
    checks++;
    if ({done0, psel} !== 2'b00) begin
      errors++; $display("[TB] FAIL wr_pulse: got %b expected 00", {done0, psel});
    end
  endtask

  task automatic test_read_wait();
    $display("[TB] test_read_wait");
    @(negedge pclk);
    req1 = 1'b1; wr1 = 1'b0; addr1 = 4'h7; pready = 1'b0; prdata = 8'h5C;
    @(negedge pclk);
    checks++;
    if ({psel, penable, pwrite, paddr} !== {3'b100, 4'h7}) begin
      errors++; $display("[TB] FAIL rd_setup: got %b/%h expected 100/7", {psel, penable, pwrite}, paddr);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      checks++;
      if ({psel, penable, pwrite, paddr, done1} !== {3'b110, 4'h7, 1'b0}) begin
        errors++; $display("[TB] FAIL rd_access%0d: got %b/%h/%b expected 110/7/0", i, {psel, penable, pwrite}, paddr, done1);
      end
      if (i == 2) pready = 1'b1;
    end
    @(negedge pclk);
    checks++;
    if ({done1, done0, err, rdata} !== {3'b100, 8'h5C}) begin
      errors++; $display("[TB] FAIL rd_done: got %b/%h expected 100/5c", {done1, done0, err}, rdata);
    end
    req1 = 1'b0; pready = 1'b0; prdata = 8'h99;
    @(negedge pclk);
    checks++;
    if (rdata !== 8'h5C) begin
      errors++; $display("[TB] FAIL rd_hold: got %h expected 5c", rdata);
    end
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    @(negedge pclk);
    Presetn = 1'b0;
    @(negedge pclk);
    Presetn = 1'b1;
    req0 = 1'b1; wr0 = 1'b1; addr0 = 4'h1; wdata0 = 8'h11;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 4'h2; wdata1 = 8'h22;
    pready = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge pclk);
      checks++;
      if ({done1, done0} !== {1'(c == 6), 1'(c == 3)}) begin
        errors++; $display("[TB] FAIL b2b_done c%0d: got %b%b expected %b%b", c, done1, done0, c == 6, c == 3);
      end
      if (c == 1 || c == 4) begin
        checks++;
        if ({psel, penable, paddr} !== {2'b10, (c == 1) ? 4'h1 : 4'h2}) begin
          errors++; $display("[TB] FAIL b2b_setup c%0d: got %b/%h", c, {psel, penable}, paddr);
        end
      end
      if (done0) req0 = 1'b0;
      if (done1) req1 = 1'b0;
    end
  endtask

  task automatic test_fairness();
    int order[$];
    $display("[TB] test_fairness");
    @(negedge pclk);
    req0 = 1'b1; wr0 = 1'b1; addr0 = 4'hA; wdata0 = 8'h10;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 4'hB; wdata1 = 8'h20;
    pready = 1'b1;
    for (int c = 0; c < 30 && order.size() < 4; c++) begin
      @(negedge pclk);
      if (done0 || done1) begin
        checks++;
        if (done0 && done1) begin
          errors++; $display("[TB] FAIL fair_both: got done0=1 done1=1 expected one");
        end
        order.push_back(done1 ? 1 : 0);
        if (order.size() == 4) begin
          req0 = 1'b0; req1 = 1'b0;
        end else if (done0) wdata0 = wdata0 + 8'd1;
        else wdata1 = wdata1 + 8'd1;
      end
    end
    checks++;
    if (order.size() != 4) begin
      errors++; $display("[TB] FAIL fair_count: got %0d transfers expected 4", order.size());
    end
    foreach (order[i]) begin
      checks++;
      if (order[i] != i % 2) begin
        errors++; $display("[TB] FAIL fair_order%0d: got %0d expected %0d", i, order[i], i % 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    $display("[TB] test_reset_mid");
    @(negedge pclk);
    req0 = 1'b1; wr0 = 1'b0; addr0 = 4'h9; pready = 1'b0; prdata = 8'h77;
    @(negedge pclk);
    @(negedge pclk);
    checks++;
    if ({psel, penable} !== 2'b11) begin
      errors++; $display("[TB] FAIL rm_access: got %b expected 11", {psel, penable});
    end
    #2 Presetn = 1'b0;
    #1;
    checks++;
    if ({psel, penable, done0, done1} !== 4'b0000) begin
      errors++; $display("[TB] FAIL rm_async: got %b expected 0000", {psel, penable, done0, done1});
    end
    @(negedge pclk);
    Presetn = 1'b1; pready = 1'b1;
    @(negedge pclk);
    checks++;
    if ({psel, penable, paddr} !== {2'b10, 4'h9}) begin
      errors++; $display("[TB] FAIL rm_restart: got %b/%h expected 10/9", {psel, penable}, paddr);
    end
    @(negedge pclk);
    @(negedge pclk);
    checks++;
    if ({done0, rdata} !== {1'b1, 8'h77}) begin
      errors++; $display("[TB] FAIL rm_done: got %b/%h expected 1/77", done0, rdata);
    end
    req0 = 1'b0;
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    int acc;
    bit seen;
    acc = 0; seen = 1'b0;
    $display("[TB] test_timeout");
    @(negedge pclk);
    req0 = 1'b1; wr0 = 1'b0; addr0 = 4'h5; pready = 1'b0; prdata = 8'hEE;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge pclk);
      if (penable) acc++;
      if (done0) begin
        seen = 1'b1;
        checks++;
        if ({err, rdata, psel} !== {1'b1, 8'h77, 1'b0}) begin
          errors++; $display("[TB] FAIL to_abort: got err=%b rdata=%h psel=%b expected 1/77/0", err, rdata, psel);
        end
        req0 = 1'b0;
      end
    end
    checks++;
    if (!seen || acc != TO_CYCLES) begin
      errors++; $display("[TB] FAIL to_cycles: got %0d access cycles (done=%b) expected %0d", acc, seen, TO_CYCLES);
    end
    @(negedge pclk);
    req0 = 1'b1; pready = 1'b1;
    repeat (3) @(negedge pclk);
    checks++;
    if ({done0, err, rdata} !== {2'b10, 8'hEE}) begin
      errors++; $display("[TB] FAIL to_recover: got %b/%b/%h expected 1/0/ee", done0, err, rdata);
    end
    req0 = 1'b0;
  endtask
`endif

  task automatic test_random();
    cmd_t          q0[$], q1[$];
    cmd_t          exp_cmd;
    logic [DW-1:0] slave_mem[16];
    logic [DW-1:0] model_mem[16];
    logic [DW-1:0] exp_rdata;
    int            model_last, exp_req, exp_done_cyc, waits, wcnt, completed, total;
    bit            active, e0, e1;
    $display("[TB] test_random");
    for (int i = 0; i < 12; i++) begin
      q0.push_back(cmd_t'($urandom));
      q1.push_back(cmd_t'($urandom));
    end
    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = DW'($urandom);
      model_mem[i] = slave_mem[i];
    end
    total = 24; completed = 0; model_last = 1; active = 1'b0;
    exp_req = 0; exp_done_cyc = 0; waits = 0; wcnt = 0; exp_cmd = '0;
    exp_rdata = '0;
    @(negedge pclk);
    Presetn = 1'b0; req0 = 1'b0; req1 = 1'b0;
    @(negedge pclk);
    Presetn = 1'b1;
    {wr0, addr0, wdata0} = q0[0]; req0 = 1'b1;
    {wr1, addr1, wdata1} = q1[0]; req1 = 1'b1;
    for (int cyc = 0; cyc < 600 && completed < total; cyc++) begin
      @(negedge pclk);
      e0 = active && cyc == exp_done_cyc && exp_req == 0;
      e1 = active && cyc == exp_done_cyc && exp_req == 1;
      checks++;
      if ({done1, done0} !== {e1, e0}) begin
        errors++; $display("[TB] FAIL rand_done cyc%0d: got %b%b expected %b%b", cyc, done1, done0, e1, e0);
      end
      if (active && cyc == exp_done_cyc) begin
        if (exp_cmd.wr) model_mem[exp_cmd.addr] = exp_cmd.data;
        else exp_rdata = model_mem[exp_cmd.addr];
        checks++;
        if ({err, rdata} !== {1'b0, exp_rdata}) begin
          errors++; $display("[TB] FAIL rand_rdata cyc%0d: got err=%b rdata=%h expected 0/%h", cyc, err, rdata, exp_rdata);
        end
        model_last = exp_req;
        active = 1'b0;
        completed++;
        if (exp_req == 0) begin
          void'(q0.pop_front());
          if (q0.size() > 0) {wr0, addr0, wdata0} = q0[0];
          else req0 = 1'b0;
        end else begin
          void'(q1.pop_front());
          if (q1.size() > 0) {wr1, addr1, wdata1} = q1[0];
          else req1 = 1'b0;
        end
      end
      if (psel && !penable) begin
        checks++;
        if (active) begin
          errors++; $display("[TB] FAIL rand_overlap cyc%0d: got SETUP expected transfer in flight", cyc);
        end
        if (q0.size() > 0 && q1.size() > 0) exp_req = 1 - model_last;
        else exp_req = (q0.size() > 0) ? 0 : 1;
        exp_cmd = (exp_req == 0) ? q0[0] : q1[0];
        checks++;
        if ({pwrite, paddr, pwdata} !== exp_cmd) begin
          errors++; $display("[TB] FAIL rand_cmd cyc%0d: got %h expected %h (req%0d)", cyc, {pwrite, paddr, pwdata}, exp_cmd, exp_req);
        end
        active = 1'b1;
        waits = $urandom_range(0, 3);
        wcnt = 0;
        exp_done_cyc = cyc + 2 + waits;
      end
      if (psel && penable) begin
        checks++;
        if ({pwrite, paddr, pwdata} !== exp_cmd) begin
          errors++; $display("[TB] FAIL rand_stable cyc%0d: got %h expected %h", cyc, {pwrite, paddr, pwdata}, exp_cmd);
        end
        pready = (wcnt >= waits);
        if (!pready) wcnt++;
        prdata = slave_mem[paddr];
        if (pready && pwrite) slave_mem[paddr] = pwdata;
      end else begin
        pready = 1'($urandom);
        prdata = DW'($urandom);
      end
    end
    checks++;
    if (completed != total) begin
      errors++; $display("[TB] FAIL rand_complete: got %0d transfers expected %0d", completed, total);
    end
    req0 = 1'b0; req1 = 1'b0; pready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_fairness();
    test_reset_mid();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
- Shares one APB master port between two independent requesters (req0, req1), e.g. a CPU-side port and a DMA-side port.
- Arbitrates round-robin and latches the winner's command.
- Sequences the APB SETUP/ACCESS phases, honours slave wait states (pready low) and returns read data with a done pulse to the winning requester.
- Sits between the requesters and the APB slave's psel/penable/pwrite/paddr/pwdata/prdata/pready pins.

Parameters:
- AW, 4, address width.
- DW, 8, data width.
- TO_CYCLES, 15, ACCESS-phase wait limit in cycles (used only with APB_TIMEOUT_EN).

Ports:
- pclk  in  1  clock, all state on rising edge.
- Presetn  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 transfer request, level, held until done0.
- wr0  in  1  requester 0 direction, 1=write, 0=read.
- addr0  in  AW  requester 0 address.
- wdata0  in  DW  requester 0 write data.
- done0  out  1  one-cycle pulse, requester 0 transfer complete.
- req1, wr1, addr1, wdata1, done1  same as requester 0, for requester 1.
- rdata  out  DW  read data of the most recent completed read, shared by both requesters.
- err  out  1  completion status, valid with done0/done1.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  AW  APB address.
- pwdata  out  DW  APB write data.
- prdata  in  DW  APB read data.
- pready  in  1  APB ready; low inserts wait states.

Behaviour:
- Reset (async, Presetn=0):
  - psel, penable, pwrite, paddr, pwdata, rdata, done0, done1 and err all 0.
  - State IDLE; last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE, arbitration:
  - Eligible requester = req high and its own done not high this cycle.
  - Mask rule: a requester may drop req one cycle after done without being re-granted.
  - Only one eligible: grant it.
  - Both eligible: grant the requester not equal to last_grant.
  - On grant: register wrX/addrX/wdataX into pwrite/paddr/pwdata, record gnt, go to SETUP.
  - Command outputs are only updated on grant; they hold their values otherwise.
- SETUP: psel=1, penable=0; unconditionally go to ACCESS next edge.
- ACCESS: psel=1, penable=1.
  - pready=0: stay in ACCESS; all APB outputs held stable.
  - pready=1 at a rising edge:
    - If read, rdata<=prdata.
    - done_gnt<=1 for one cycle; err<=0.
    - last_grant<=gnt.
    - psel<=0, penable<=0; go to IDLE.
- Latency: req sampled at edge E0 → psel=1 after E0 → penable=1 after E1 → zero-wait completion at E2 → done high during cycle after E2.
- Throughput: minimum 3 cycles per transfer; each wait state adds 1 cycle.
- Back-to-back: the done cycle is an IDLE cycle, so arbitration happens in the same cycle done pulses; the next SETUP follows immediately. A requester asking again while the other waits loses the tie.
- req deasserted after grant: the transfer still completes; req is not re-sampled until IDLE.
- rdata is unchanged by write transfers.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A 4-bit+ counter clears on SETUP and increments each ACCESS cycle with pready=0.
  - When the count reaches TO_CYCLES with pready still 0: abort the transfer. psel/penable go to 0 and state returns to IDLE.
  - done_gnt and err are both high for one cycle; rdata is unchanged; last_grant is updated.
- Undefined: no counter; ACCESS waits indefinitely; err is tied 0.

Test Plan:
- Write only: req0=1, wr0=1, addr0=4'h3, wdata0=8'hA5, pready=1 → SETUP then ACCESS with paddr=3, pwdata=A5, pwrite=1; done0 pulses 3 cycles after req; err=0.
- Read with waits: slave holds pready=0 for 2 ACCESS cycles, prdata=8'h5C; req1 read of addr1=4'h7 → penable high for 3 cycles, outputs stable throughout; rdata=5C with done1.
- Simultaneous requests after reset: req0 and req1 both high → req0 served first, then req1 with no idle gap beyond the done cycle; done0 and done1 in that order.
- Fairness: both requests held continuously for 4 transfers → grant order 0,1,0,1; done never asserts for both requesters in the same cycle.
- Reset mid-ACCESS: Presetn low while penable=1 → psel/penable/done drop immediately (asynchronously); after release, the pending req0 restarts from SETUP.
- With APB_TIMEOUT_EN: pready held 0, TO_CYCLES=15 → abort after 15 ACCESS cycles, done0=1 and err=1, rdata unchanged; the next transfer with pready=1 completes with err=0.
